// File: rtl/bounce_generator.sv
// Switch-bounce emulator: turns a clean requested level into a pseudo-random
// toggling burst that settles on that level, then holds it before signalling done.
module bounce_generator #(
    parameter int unsigned BOUNCE_PAIRS  = 4,
    parameter int unsigned GAP_W         = 4,
    parameter int unsigned SETTLE_CYCLES = 64,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       clean_in,
    output logic       trigger,
    output logic       busy,
    output logic       done,
    output logic [7:0] burst_count
);

    localparam int unsigned TogW    = $clog2(2 * BOUNCE_PAIRS + 2);
    localparam int unsigned SetW    = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [TogW-1:0] TogInit = TogW'(2 * BOUNCE_PAIRS + 1);
    localparam logic [SetW-1:0] SetInit = SetW'(SETTLE_CYCLES);
    localparam logic [15:0] SeedEff  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [15:0] LfsrMask = 16'hB400;

    typedef enum logic [1:0] {StIdle, StBounce, StSettle} state_e;

    state_e            state_q, state_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [TogW-1:0]   tog_q, tog_d;
    logic [SetW-1:0]   set_q, set_d;
    logic              trig_q, trig_d;
    logic              target_q, target_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [7:0]        cnt_q, cnt_d;

    logic [15:0]       lfsr_step;
    logic [GAP_W-1:0]  gap_load;

    // The LFSR only advances when a gap is consumed, keeping bursts reproducible from reset.
    assign lfsr_step = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LfsrMask : 16'h0000);
    assign gap_load  = (lfsr_q[GAP_W-1:0] == '0) ? GAP_W'(1) : lfsr_q[GAP_W-1:0];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            lfsr_q   <= SeedEff;
            gap_q    <= '0;
            tog_q    <= '0;
            set_q    <= '0;
            trig_q   <= 1'b0;
            target_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            gap_q    <= gap_d;
            tog_q    <= tog_d;
            set_q    <= set_d;
            trig_q   <= trig_d;
            target_q <= target_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        gap_d    = gap_q;
        tog_d    = tog_q;
        set_d    = set_q;
        trig_d   = trig_q;
        target_d = target_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        cnt_d    = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (!enable) begin
                    trig_d = clean_in;
                end else if (clean_in != trig_q) begin
                    target_d = clean_in;
                    tog_d    = TogInit;
                    gap_d    = gap_load;
                    lfsr_d   = lfsr_step;
                    busy_d   = 1'b1;
                    state_d  = StBounce;
                end
            end
            StBounce: begin
                if (gap_q == GAP_W'(1)) begin
                    trig_d = ~trig_q;
                    tog_d  = tog_q - TogW'(1);
                    if (tog_q == TogW'(1)) begin
                        set_d   = SetInit;
                        state_d = StSettle;
                    end else begin
                        gap_d  = gap_load;
                        lfsr_d = lfsr_step;
                    end
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            StSettle: begin
                trig_d = target_q;
                if (set_q == SetW'(1)) begin
                    done_d  = 1'b1;
                    cnt_d   = cnt_q + 8'd1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    set_d = set_q - SetW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        trigger     = trig_q;
        busy        = busy_q;
        done        = done_q;
        burst_count = cnt_q;
    end

endmodule

// File: tb/tb_bounce_generator.sv
// Bench for bounce_generator: a default instance and a single-toggle, short-settle instance,
// both checked cycle by cycle against a gap-sequence model of the bounce waveform.
module tb_bounce_generator;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [1:0] en;
    logic [1:0] cin;
    logic [1:0] trig;
    logic [1:0] bsy;
    logic [1:0] dn;
    logic [7:0] cnt0;
    logic [7:0] cnt1;

    int tests = 0;
    int fails = 0;

    logic [15:0] mlfsr [2];
    logic        mtrig [2];
    logic [7:0]  mcnt  [2];
    int          pairs  [2] = '{4, 0};
    int          settle [2] = '{64, 2};

    always #5 clock = ~clock;

    bounce_generator u_dut0 (
        .clock       (clock),
        .reset_n     (reset_n),
        .enable      (en[0]),
        .clean_in    (cin[0]),
        .trigger     (trig[0]),
        .busy        (bsy[0]),
        .done        (dn[0]),
        .burst_count (cnt0)
    );

    bounce_generator #(
        .BOUNCE_PAIRS  (0),
        .SETTLE_CYCLES (2)
    ) u_dut1 (
        .clock       (clock),
        .reset_n     (reset_n),
        .enable      (en[1]),
        .clean_in    (cin[1]),
        .trigger     (trig[1]),
        .busy        (bsy[1]),
        .done        (dn[1]),
        .burst_count (cnt1)
    );

    function automatic logic [7:0] cnt_of(input int d);
        return (d == 0) ? cnt0 : cnt1;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Next gap from the spec's Galois LFSR, expressed as plain arithmetic.
    function automatic int next_gap(input int d);
        int g;
        g = int'(mlfsr[d] % 16);
        if (g == 0) g = 1;
        mlfsr[d] = (mlfsr[d] >> 1) ^ (((mlfsr[d] & 16'h1) != 0) ? 16'hB400 : 16'h0000);
        return g;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mlfsr[d] = 16'hACE1;
            mtrig[d] = 1'b0;
            mcnt[d]  = 8'd0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            for (int d = 0; d < 2; d++) begin
                check("idle_trig", trig[d], mtrig[d]);
                check("idle_busy", bsy[d], 0);
                check("idle_done", dn[d], 0);
            end
        end
    endtask

    task automatic bypass(input int n);
        logic [1:0] v;
        en = 2'b00;
        for (int i = 0; i < n; i++) begin
            v   = 2'($urandom);
            cin = v;
            tick();
            for (int d = 0; d < 2; d++) begin
                check("byp_trig", trig[d], v[d]);
                check("byp_busy", bsy[d], 0);
                check("byp_done", dn[d], 0);
                check("byp_cnt", cnt_of(d), mcnt[d]);
            end
        end
        mtrig[0] = cin[0];
        mtrig[1] = cin[1];
        en = 2'b11;
    endtask

    // One full burst on instance d towards lvl; optional abort by reset after abort_edges edges.
    task automatic burst(input int d, input logic lvl, input int abort_edges, input bit flip,
                         input bit drop_en);
        int   g;
        int   n;
        logic cur;
        n      = 2 * pairs[d] + 1;
        cin[d] = lvl;
        tick();
        check("start_busy", bsy[d], 1);
        check("start_trig", trig[d], mtrig[d]);
        check("start_done", dn[d], 0);
        cur = mtrig[d];
        for (int k = 0; k < n; k++) begin
            g = next_gap(d);
            for (int j = 1; j <= g; j++) begin
                tick();
                if (j < g) begin
                    check("gap_hold", trig[d], cur);
                end else begin
                    cur = ~cur;
                    check("edge", trig[d], cur);
                end
                check("bounce_busy", bsy[d], 1);
                check("bounce_done", dn[d], 0);
            end
            if (k == 0 && flip) cin[d] = ~lvl;
            if (k == 0 && drop_en) en[d] = 1'b0;
            if (abort_edges == k + 1) begin
                #2 reset_n = 1'b0;
                cin = 2'b00;
                #1;
                check("abort_trig", trig[d], 0);
                check("abort_busy", bsy[d], 0);
                check("abort_done", dn[d], 0);
                @(negedge clock);
                reset_n = 1'b1;
                en      = 2'b11;
                model_reset();
                check("abort_cnt", cnt_of(d), mcnt[d]);
                return;
            end
        end
        for (int j = 1; j <= settle[d]; j++) begin
            tick();
            check("settle_trig", trig[d], lvl);
            if (j < settle[d]) begin
                check("settle_done", dn[d], 0);
                check("settle_busy", bsy[d], 1);
            end else begin
                mcnt[d] = mcnt[d] + 8'd1;
                check("done_pulse", dn[d], 1);
                check("done_busy", bsy[d], 0);
                check("done_cnt", cnt_of(d), mcnt[d]);
            end
        end
        mtrig[d] = lvl;
        en[d]    = 1'b1;
    endtask

    initial begin
        logic [7:0] wrap_start;
        reset_n = 1'b0;
        en      = 2'b11;
        cin     = 2'b00;
        model_reset();
        #3;
        for (int d = 0; d < 2; d++) begin
            check("rst_trig", trig[d], 0);
            check("rst_busy", bsy[d], 0);
            check("rst_done", dn[d], 0);
            check("rst_cnt", cnt_of(d), 0);
        end
        @(negedge clock);
        reset_n = 1'b1;
        idle(2);

        burst(0, 1'b1, 0, 1'b0, 1'b0);
        burst(0, 1'b0, 3, 1'b0, 1'b0);
        idle(2);
        burst(0, 1'b1, 0, 1'b0, 1'b0);

        burst(0, 1'b0, 0, 1'b1, 1'b0);
        burst(0, 1'b1, 0, 1'b0, 1'b0);
        check("b2b_cnt", cnt0, 8'd3);

        for (int r = 0; r < 5; r++) begin
            idle(int'($urandom_range(0, 4)));
            burst(0, ~mtrig[0], 0, 1'b0, 1'($urandom));
        end

        bypass(40);
        idle(1);

        burst(1, ~mtrig[1], 0, 1'b0, 1'b0);
        wrap_start = mcnt[1];
        for (int r = 0; r < 256; r++) begin
            if (($urandom % 4) == 0) idle(1);
            burst(1, ~mtrig[1], 0, 1'b0, 1'b0);
        end
        check("wrap_cnt", cnt1, wrap_start);
        idle(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
